// File: rtl/supply_ramp_pkg.sv
// supply_ramp_pkg: shared types and code-to-volts helper
// for the slew-limited supply DAC.
package supply_ramp_pkg;

  typedef enum logic {
    IDLE,
    RAMP
  } ramp_state_e;

  typedef enum logic {
    UP,
    DOWN
  } ramp_dir_e;

  function automatic real code_to_volts(
    input logic [31:0] c,
    input int          w,
    input real         vref
  );
    return real'(c) * vref / real'(64'd1 << w);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: loadable down-counter, ticks at zero and
// reloads itself while enabled.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = $clog2(DWELL) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load || (i_en && o_tick)) begin
      r_cnt <= RELOAD;
    end else if (i_en) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/supply_ramp_dac.sv
// supply_ramp_dac: slew-limited DAC code ramp driving a
// real-valued supply net.
module supply_ramp_dac
  import supply_ramp_pkg::*;
#(
  parameter int  CODE_W = 10,
  parameter real VREF   = 1.0,
  parameter int  STEP   = 1,
  parameter int  DWELL  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CODE_W-1:0] target,
  input  logic              abort,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [CODE_W-1:0] code,
  output real               vout
);

  localparam logic [CODE_W:0]   STEP_W = (CODE_W + 1)'(STEP);
  localparam logic [CODE_W-1:0] STEP_C = CODE_W'(STEP);

  ramp_state_e       r_state;
  ramp_dir_e         r_dir;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] r_tgt;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;

  logic              w_tick;
  logic              w_load;
  logic              w_en;
  logic [CODE_W:0]   w_diff;
  logic              w_last;
  logic [CODE_W-1:0] w_next;

  assign w_load = (r_state == IDLE) && start && !abort
                  && (target != r_code);
  assign w_en   = (r_state == RAMP);

  dwell_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_en    (w_en),
    .o_tick  (w_tick)
  );

  // Distance is taken one bit wider so the clamp never wraps.
  always_comb begin
    w_diff = '0;
    w_next = r_code;
    if (r_dir == UP) begin
      w_diff = {1'b0, r_tgt} - {1'b0, r_code};
    end else begin
      w_diff = {1'b0, r_code} - {1'b0, r_tgt};
    end
    w_last = (w_diff <= STEP_W);
    if (w_last) begin
      w_next = r_tgt;
    end else if (r_dir == UP) begin
      w_next = r_code + STEP_C;
    end else begin
      w_next = r_code - STEP_C;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_dir   <= UP;
      r_code  <= '0;
      r_tgt   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_tgt <= target;
            if (target == r_code) begin
              r_done <= 1'b1;
            end else begin
              r_state <= RAMP;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
              r_dir   <= (target > r_code) ? UP : DOWN;
            end
          end
        end
        RAMP: begin
          // Landing on the target beats a coincident abort.
          if (w_tick && (w_last || !abort)) begin
            r_code <= w_next;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else if (abort) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign code  = r_code;
  assign vout  = code_to_volts(32'(r_code), CODE_W, VREF);

endmodule

// File: tb/tb_supply_ramp_dac.sv
// tb_supply_ramp_dac: scoreboard bench, ramp model queues
// expected code updates and done pulses by edge number.
module tb_supply_ramp_dac;

  localparam int  CODE_W = 10;
  localparam real VREF   = 1.0;
  localparam int  STEP   = 2;
  localparam int  DWELL  = 4;
  localparam int  MAXC   = (1 << CODE_W) - 1;

  typedef struct {
    int e;
    int v;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              start = 1'b0;
  logic [CODE_W-1:0] target = '0;
  logic              abort = 1'b0;
  logic              ready;
  logic              busy;
  logic              done;
  logic [CODE_W-1:0] code;
  real               vout;

  supply_ramp_dac #(
    .CODE_W (CODE_W),
    .VREF   (VREF),
    .STEP   (STEP),
    .DWELL  (DWELL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .target  (target),
    .abort   (abort),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .code    (code),
    .vout    (vout)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;
  int   mc = 0;
  int   busy_from = 0;
  int   busy_to = 0;
  bit   mon_en = 1'b0;
  int   prev = 0;
  exp_t cq[$];
  exp_t dq[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic real volts(input int c);
    return real'(c) * VREF / real'(1 << CODE_W);
  endfunction

  function automatic int step_to(input int c, input int t);
    int d;
    d = (t > c) ? t - c : c - t;
    if (d <= STEP) return t;
    return (t > c) ? c + STEP : c - STEP;
  endfunction

  task automatic check(input string nm, input bit ok,
                       input int act, input int req);
    ncmp++;
    if (!ok) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0d want %0d",
               nm, cyc, act, req);
    end
  endtask

  // Monitor: compares DUT activity against queued expectations.
  always @(negedge clk) begin
    exp_t x;
    bit   eb;
    if (!mon_en) begin
      prev = int'(code);
    end else begin
      eb = (cyc >= busy_from) && (cyc < busy_to);
      check("busy", busy === eb, int'(busy), int'(eb));
      check("ready", ready === !eb, int'(ready), int'(!eb));
      if (int'(code) != prev) begin
        if (cq.size() == 0) begin
          check("unexpected_code", 1'b0, int'(code), prev);
        end else begin
          x = cq.pop_front();
          check("code_val", int'(code) == x.v, int'(code), x.v);
          check("code_edge", cyc == x.e, cyc, x.e);
          check("code_vout", vout == volts(x.v),
                int'(vout * 1e6), int'(volts(x.v) * 1e6));
        end
        prev = int'(code);
      end
      while (cq.size() > 0 && cq[0].e < cyc) begin
        x = cq.pop_front();
        check("missing_code", 1'b0, int'(code), x.v);
      end
      if (done === 1'b1) begin
        if (dq.size() == 0) begin
          check("unexpected_done", 1'b0, 1, 0);
        end else begin
          x = dq.pop_front();
          check("done_edge", cyc == x.e, cyc, x.e);
          check("done_code", int'(code) == x.v, int'(code), x.v);
          check("done_vout", vout == volts(x.v),
                int'(vout * 1e6), int'(volts(x.v) * 1e6));
        end
      end
      while (dq.size() > 0 && dq[0].e < cyc) begin
        x = dq.pop_front();
        check("missing_done", 1'b0, 0, 1);
      end
    end
  end

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  // One start request; ab>0 aborts at start_edge+ab, ab<0 random.
  task automatic txn(input int t, input int ab,
                     input bit ab_idle, input bit spur);
    int s, n, d, last, cn, a;
    bit fin;
    start  = 1'b1;
    target = CODE_W'(t);
    abort  = ab_idle;
    tick1();
    s = cyc;
    start = 1'b0;
    abort = 1'b0;
    if (ab_idle) return;
    if (t == mc) begin
      dq.push_back('{e: s, v: t});
      return;
    end
    d = (t > mc) ? t - mc : mc - t;
    n = (d + STEP - 1) / STEP;
    a = ab;
    if (a < 0) a = $urandom_range(1, n * DWELL);
    fin = (a == 0) || (a == n * DWELL);
    cn = mc;
    for (int k = 1; k <= n; k++) begin
      if (a != 0 && k * DWELL > a) break;
      if (a != 0 && k * DWELL == a && k != n) break;
      cn = step_to(cn, t);
      cq.push_back('{e: s + k * DWELL, v: cn});
    end
    last = fin ? s + n * DWELL : s + a;
    busy_from = s;
    busy_to   = last;
    if (fin) dq.push_back('{e: last, v: t});
    while (cyc < last) begin
      abort  = (a != 0) && (cyc + 1 == s + a);
      start  = spur && ($urandom_range(0, 2) == 0);
      target = spur ? CODE_W'(1) : CODE_W'($urandom);
      tick1();
    end
    abort = 1'b0;
    start = 1'b0;
    mc = cn;
  endtask

  initial begin
    int lo, hi, t, gap;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_code", code == '0, int'(code), 0);
    check("rst_vout", vout == 0.0, int'(vout * 1e6), 0);
    check("rst_ready", ready === 1'b1, int'(ready), 1);
    check("rst_busy", busy === 1'b0, int'(busy), 0);
    check("rst_done", done === 1'b0, int'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    tick1();

    txn(8, 0, 1'b0, 1'b0);
    tick1();
    txn(3, 0, 1'b0, 1'b0);
    txn(3, 0, 1'b0, 1'b0);
    tick1();
    txn(13, 8, 1'b0, 1'b1);
    tick1();
    txn(9, 8, 1'b0, 1'b0);
    txn(20, 0, 1'b1, 1'b0);
    tick1();
    txn(1014, 0, 1'b0, 1'b0);
    txn(1023, 0, 1'b0, 1'b0);
    txn(1022, 0, 1'b0, 1'b0);
    txn(0, 0, 1'b0, 1'b0);
    repeat (2) tick1();

    // Asynchronous reset in the middle of a ramp.
    mon_en = 1'b0;
    start  = 1'b1;
    target = CODE_W'(30);
    tick1();
    start = 1'b0;
    repeat (9) tick1();
    check("mid_code", int'(code) == 2 * STEP, int'(code), 2 * STEP);
    check("mid_busy", busy === 1'b1, int'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_code", code == '0, int'(code), 0);
    check("arst_vout", vout == 0.0, int'(vout * 1e6), 0);
    check("arst_ready", ready === 1'b1, int'(ready), 1);
    check("arst_busy", busy === 1'b0, int'(busy), 0);
    check("arst_done", done === 1'b0, int'(done), 0);
    tick1();
    reset_n = 1'b1;
    mc = 0;
    busy_from = 0;
    busy_to   = 0;
    tick1();
    mon_en = 1'b1;
    tick1();

    for (int i = 0; i < 40; i++) begin
      lo = (mc > 40) ? mc - 40 : 0;
      hi = (mc + 40 < MAXC) ? mc + 40 : MAXC;
      t  = $urandom_range(lo, hi);
      if ($urandom_range(0, 9) == 0) t = mc;
      txn(t, ($urandom_range(0, 3) == 0) ? -1 : 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        abort = $urandom_range(0, 1) == 1;
        tick1();
      end
      abort = 1'b0;
    end

    repeat (DWELL + 3) tick1();
    check("cq_empty", cq.size() == 0, cq.size(), 0);
    check("dq_empty", dq.size() == 0, dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
